// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller.
// Walks each instruction through FETCH/DECODE/EXECUTE/WRITE_BACK, with wait
// states for instruction fetch, data memory and generic multicycle units.
// A shared watchdog bounds every wait state. Traps record their cause, and
// completed instructions are counted.
module multicycle_ctrl #(
  parameter int NUM_UNITS = 2,
  parameter int TIMEOUT   = 255,
  parameter int TMO_W     = 8,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_busy,
  input  logic                 decoder_illegal,
  input  logic                 is_load_store,
  input  logic                 mem_busy,
  input  logic                 mem_fault,
  input  logic [NUM_UNITS-1:0] unit_req,
  input  logic [NUM_UNITS-1:0] unit_busy,
  output logic [2:0]           state,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic                 rf_we,
  output logic                 pc_en,
  output logic                 trap_valid,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     retire_count
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'b000,
    S_DECODE     = 3'b001,
    S_EXECUTE    = 3'b010,
    S_WRITE_BACK = 3'b011,
    S_MEM_WAIT   = 3'b100,
    S_TRAP       = 3'b101,
    S_UNIT_WAIT  = 3'b110,
    S_FETCH_WAIT = 3'b111
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEM     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // Watchdog limit; a limit of zero turns the watchdog off entirely.
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam bit               TMO_EN    = (TIMEOUT != 0);

  state_t                 state_reg, state_next;
  logic [TMO_W-1:0]       wd_reg, wd_next;
  logic [NUM_UNITS-1:0]   sel_reg, sel_next;
  logic [NUM_UNITS-1:0]   unit_start_reg, unit_start_next;
  logic [1:0]             cause_reg, cause_next;
  logic [CNT_W-1:0]       retire_reg, retire_next;

  logic [NUM_UNITS-1:0]   low_req;
  logic                   in_wait;
  logic                   wait_busy;
  logic                   timeout;
  logic                   unit_first;

  // Isolate the lowest-index requesting unit (one-hot); lower index wins ties.
  always_comb begin
    low_req = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (unit_req[i]) begin
        low_req    = '0;
        low_req[i] = 1'b1;
      end
    end
  end

  // Busy condition of whichever wait state is active; drives the watchdog trip.
  always_comb begin
    wait_busy = 1'b0;
    in_wait   = 1'b0;
    case (state_reg)
      S_FETCH_WAIT: begin
        in_wait   = 1'b1;
        wait_busy = fetch_busy;
      end
      S_MEM_WAIT: begin
        in_wait   = 1'b1;
        wait_busy = mem_busy;
      end
      S_UNIT_WAIT: begin
        in_wait   = 1'b1;
        wait_busy = |(unit_busy & sel_reg);
      end
      default: begin
        in_wait   = 1'b0;
        wait_busy = 1'b0;
      end
    endcase
  end

  assign timeout    = TMO_EN && (wd_reg == TMO_LIMIT) && wait_busy;
  // The start pulse is present exactly during the first UNIT_WAIT cycle,
  // so it doubles as the "ignore busy this cycle" marker.
  assign unit_first = |unit_start_reg;

  // Next-state, trap-cause, unit-select and strobe decode.
  always_comb begin
    state_next      = state_reg;
    cause_next      = cause_reg;
    sel_next        = sel_reg;
    unit_start_next = '0;
    rf_we           = 1'b0;
    pc_en           = 1'b0;
    trap_valid      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        state_next = fetch_busy ? S_FETCH_WAIT : S_DECODE;
      end
      S_FETCH_WAIT: begin
        if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (!fetch_busy) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (decoder_illegal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (|unit_req) begin
          state_next      = S_UNIT_WAIT;
          sel_next        = low_req;
          unit_start_next = low_req;
        end else if (is_load_store) begin
          state_next = S_MEM_WAIT;
        end else begin
          state_next = S_WRITE_BACK;
        end
      end
      S_UNIT_WAIT: begin
        if (!unit_first) begin
          if (timeout) begin
            state_next = S_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end else if (!(|(unit_busy & sel_reg))) begin
            state_next = S_WRITE_BACK;
          end
        end
      end
      S_MEM_WAIT: begin
        if (mem_fault) begin
          state_next = S_TRAP;
          cause_next = CAUSE_MEM;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (!mem_busy) begin
          state_next = S_WRITE_BACK;
        end
      end
      S_WRITE_BACK: begin
        rf_we      = 1'b1;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap_valid = 1'b1;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Watchdog restarts on any state change and saturates while waiting.
  always_comb begin
    wd_next = wd_reg;
    if (state_next != state_reg) begin
      wd_next = '0;
    end else if (in_wait && (wd_reg != TMO_LIMIT)) begin
      wd_next = wd_reg + TMO_W'(1);
    end
  end

  // Retire counter advances once per WRITE_BACK, wrapping naturally.
  always_comb begin
    retire_next = retire_reg;
    if (state_reg == S_WRITE_BACK) begin
      retire_next = retire_reg + CNT_W'(1);
    end
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_FETCH;
      wd_reg         <= '0;
      sel_reg        <= '0;
      unit_start_reg <= '0;
      cause_reg      <= CAUSE_NONE;
      retire_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      wd_reg         <= wd_next;
      sel_reg        <= sel_next;
      unit_start_reg <= unit_start_next;
      cause_reg      <= cause_next;
      retire_reg     <= retire_next;
    end
  end

  assign state        = state_reg;
  assign unit_start   = unit_start_reg;
  assign trap_cause   = cause_reg;
  assign retire_count = retire_reg;

endmodule
